// File: rtl/cdb_if.sv
// Common Data Bus bundle: per-unit result requests in, one-hot grant and registered broadcast out.
interface cdb_if #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_UNITS-1:0]        req;
  logic [NUM_UNITS*TAG_W-1:0]  req_tag;
  logic [NUM_UNITS*DATA_W-1:0] req_data;
  logic [NUM_UNITS-1:0]        grant;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_data;

  // Functional units drive requests and snoop grant/CDB.
  modport master (
    output req, req_tag, req_data,
    input  grant, cdb_valid, cdb_tag, cdb_data
  );

  // Arbiter consumes requests and owns grant/CDB.
  modport slave (
    input  req, req_tag, req_data,
    output grant, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one finished functional unit per cycle and
// broadcasts its tag/result on a registered bus one cycle later.
module cdb_arbiter #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  cdb_if.slave   bus
);

  localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]     r_prio_ptr;
  logic                 r_cdb_valid;
  logic [TAG_W-1:0]     r_cdb_tag;
  logic [DATA_W-1:0]    r_cdb_data;

  logic                 w_found;
  logic                 w_fire;
  logic [PTR_W-1:0]     w_winner;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [NUM_UNITS-1:0] w_grant;
  logic [TAG_W-1:0]     w_tags  [NUM_UNITS];
  logic [DATA_W-1:0]    w_datas [NUM_UNITS];

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign w_tags[g]  = bus.req_tag[g*TAG_W +: TAG_W];
    assign w_datas[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // First requester at or after the priority pointer, wrapping modulo NUM_UNITS.
  always_comb begin
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      idx = (32'(r_prio_ptr) + k) % NUM_UNITS;
      if (!w_found && bus.req[PTR_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
  end

  // Reset and flush suppress the grant while leaving requests pending.
  assign w_fire     = w_found && rst_n && !flush;
  assign w_grant    = w_fire ? (NUM_UNITS'(1) << w_winner) : '0;
  assign w_next_ptr = (32'(w_winner) == NUM_UNITS - 1) ? '0 : w_winner + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio_ptr  <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else begin
      r_cdb_valid <= w_fire;
      if (w_fire) begin
        r_prio_ptr <= w_next_ptr;
        r_cdb_tag  <= w_tags[w_winner];
        r_cdb_data <= w_datas[w_winner];
      end
    end
  end

  assign bus.grant     = w_grant;
  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_data  = r_cdb_data;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(w_grant));
  a_grant_blocked: assert property (@(posedge clk) (!rst_n || flush) |-> (w_grant == '0));

endmodule
